// File: rtl/adc_spi_responder.sv
// adc_spi_responder: slave end of an LTC2308-style SCLK/CONVST/SDI/SDO link.
// Receives the 6-bit config word on SDI and emulates the conversion time.
// It then shifts the 12-bit result for the selected channel out on SDO.
// Sample values come from the parallel CH_DATA bus.
// SCLK_MIN_HALF is the minimum SCLK half-period (in CLOCK cycles) that the master must honour.
// The optional macro ADC_RESP_NOISE_EN adds LFSR-driven noise in the range -2..+1 to every valid sample.
module adc_spi_responder #(
   parameter int NUM_CH        = 8,
   parameter int T_CONV        = 80,
   parameter int SCLK_MIN_HALF = 4
) (
   input  logic                 CLOCK,
   input  logic                 RESET,
   input  logic                 ADC_SCLK,
   input  logic                 ADC_CONVST,
   input  logic                 ADC_SDI,
   output logic                 ADC_SDO,
   input  logic [NUM_CH*12-1:0] CH_DATA,
   output logic                 busy,
   output logic                 frame_done,
   output logic [5:0]           last_cfg,
   output logic                 cfg_err
);

   localparam int         CNT_W    = (T_CONV > 1) ? $clog2(T_CONV) : 1;
   localparam logic [3:0] NUM_CH_L = 4'(NUM_CH);
   localparam logic [5:0] CFG_RESET = 6'b100010;   // single-ended CH0, unipolar

   // Parameter sanity: channel mux is 3 bits wide, edge detector needs levels of 2+ clocks
   if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
      $error("adc_spi_responder: NUM_CH must be in 2..8");
   end
   if (SCLK_MIN_HALF < 2) begin : g_bad_sclk_half
      $error("adc_spi_responder: SCLK_MIN_HALF must be at least 2");
   end
   if (T_CONV < 1) begin : g_bad_t_conv
      $error("adc_spi_responder: T_CONV must be at least 1");
   end

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      WAIT_XFER,
      XFER
   } state_t;

   genvar gi;

   // Synchroniser chain: bit 0 = SCLK, bit 1 = CONVST, bit 2 = SDI
   logic [2:0] meta_reg;
   logic [2:0] sync_reg;
   logic [1:0] prev_reg;

   logic sclk_rise;
   logic sclk_fall;
   logic conv_rise;
   logic conv_fall;
   logic sdi_s;

   state_t           state_reg,       state_next;
   logic [CNT_W-1:0] cnt_reg,         cnt_next;
   logic             busy_reg,        busy_next;
   logic [2:0]       conv_ch_reg,     conv_ch_next;
   logic             conv_ok_reg,     conv_ok_next;
   logic [11:0]      result_reg,      result_next;
   logic [11:0]      sdo_shift_reg,   sdo_shift_next;
   logic             sdo_reg,         sdo_next;
   logic [5:0]       cfg_shift_reg,   cfg_shift_next;
   logic [2:0]       rise_cnt_reg,    rise_cnt_next;
   logic [3:0]       fall_cnt_reg,    fall_cnt_next;
   logic [5:0]       pending_cfg_reg, pending_cfg_next;
   logic [5:0]       last_cfg_reg,    last_cfg_next;
   logic             cfg_err_reg,     cfg_err_next;
   logic             frame_done_reg,  frame_done_next;

   logic        start_conv;
   logic        conv_done;
   logic [2:0]  pend_ch;
   logic        pend_ok;
   logic [11:0] ch_word [0:7];
   logic [11:0] raw_val;
   logic [11:0] sample_val;

   // Two-flop synchronisers followed by one edge-detect stage for SCLK and CONVST
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         meta_reg <= 3'b000;
         sync_reg <= 3'b000;
         prev_reg <= 2'b00;
      end else begin
         meta_reg <= {ADC_SDI, ADC_CONVST, ADC_SCLK};
         sync_reg <= meta_reg;
         prev_reg <= sync_reg[1:0];
      end
   end

   assign sclk_rise = sync_reg[0] & ~prev_reg[0];
   assign sclk_fall = ~sync_reg[0] & prev_reg[0];
   assign conv_rise = sync_reg[1] & ~prev_reg[1];
   assign conv_fall = ~sync_reg[1] & prev_reg[1];
   assign sdi_s     = sync_reg[2];

   // Unpack the channel bus into an 8-entry table; absent channels read as zero
   for (gi = 0; gi < 8; gi++) begin : g_ch
      if (gi < NUM_CH) begin : g_used
         assign ch_word[gi] = CH_DATA[12*gi +: 12];
      end else begin : g_unused
         assign ch_word[gi] = 12'h000;
      end
   end

   // Config bits are {S/D, O/S, S1, S0, UNI, SLP}; single-ended channel is {S1, S0, O/S}
   assign pend_ch = {pending_cfg_reg[3], pending_cfg_reg[2], pending_cfg_reg[4]};
   assign pend_ok = pending_cfg_reg[5] && ({1'b0, pend_ch} < NUM_CH_L);

   assign conv_done = busy_reg && (cnt_reg == '0);
   assign raw_val   = conv_ok_reg ? ch_word[conv_ch_reg] : 12'h000;

`ifdef ADC_RESP_NOISE_EN
   logic [15:0] lfsr_reg;
   logic [13:0] noisy_sum;

   assign noisy_sum = {2'b00, raw_val} + {{12{lfsr_reg[1]}}, lfsr_reg[1:0]};

   // Saturating noise add; invalid configurations still return a hard zero
   always_comb begin
      sample_val = raw_val;
      if (conv_ok_reg) begin
         if (noisy_sum[13]) begin
            sample_val = 12'h000;
         end else if (noisy_sum[12]) begin
            sample_val = 12'hFFF;
         end else begin
            sample_val = noisy_sum[11:0];
         end
      end
   end

   // Galois LFSR steps once per finished conversion
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         lfsr_reg <= 16'hACE1;
      end else if (conv_done) begin
         lfsr_reg <= {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
      end
   end
`else
   assign sample_val = raw_val;
`endif

   // Next-state and datapath logic; the conversion timer runs independently of the frame state
   always_comb begin
      state_next       = state_reg;
      cnt_next         = cnt_reg;
      busy_next        = busy_reg;
      conv_ch_next     = conv_ch_reg;
      conv_ok_next     = conv_ok_reg;
      result_next      = result_reg;
      sdo_shift_next   = sdo_shift_reg;
      sdo_next         = sdo_reg;
      cfg_shift_next   = cfg_shift_reg;
      rise_cnt_next    = rise_cnt_reg;
      fall_cnt_next    = fall_cnt_reg;
      pending_cfg_next = pending_cfg_reg;
      last_cfg_next    = last_cfg_reg;
      cfg_err_next     = cfg_err_reg;
      frame_done_next  = 1'b0;
      start_conv       = 1'b0;

      // Background timer so an early transfer does not stall the conversion
      if (busy_reg) begin
         if (cnt_reg == '0) begin
            busy_next   = 1'b0;
            result_next = sample_val;
         end else begin
            cnt_next = cnt_reg - 1'b1;
         end
      end

      case (state_reg)
         IDLE: begin
            if (conv_rise) begin
               start_conv = 1'b1;
            end
         end
         CONV: begin
            if (conv_fall) begin
               // Master opened the frame too early: ship the previous result
               state_next     = XFER;
               cfg_err_next   = 1'b1;
               sdo_shift_next = result_reg;
               sdo_next       = result_reg[11];
               rise_cnt_next  = 3'd0;
               fall_cnt_next  = 4'd0;
            end else if (conv_done) begin
               state_next     = WAIT_XFER;
               sdo_shift_next = sample_val;
               sdo_next       = sample_val[11];
            end
         end
         WAIT_XFER: begin
            if (conv_rise) begin
               start_conv = 1'b1;
            end else if (conv_fall) begin
               state_next    = XFER;
               rise_cnt_next = 3'd0;
               fall_cnt_next = 4'd0;
            end
         end
         XFER: begin
            if (conv_rise) begin
               // Abort: frame is dropped without touching the config
               start_conv = 1'b1;
            end else begin
               if (sclk_rise && (rise_cnt_reg != 3'd6)) begin
                  cfg_shift_next = {cfg_shift_reg[4:0], sdi_s};
                  rise_cnt_next  = rise_cnt_reg + 1'b1;
               end
               if (sclk_fall) begin
                  if (fall_cnt_reg == 4'd11) begin
                     sdo_next        = 1'b0;
                     frame_done_next = 1'b1;
                     state_next      = IDLE;
                     if (rise_cnt_reg == 3'd6) begin
                        pending_cfg_next = cfg_shift_reg;
                        last_cfg_next    = cfg_shift_reg;
                     end
                  end else begin
                     sdo_shift_next = {sdo_shift_reg[10:0], 1'b0};
                     sdo_next       = sdo_shift_reg[10];
                     fall_cnt_next  = fall_cnt_reg + 1'b1;
                  end
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (start_conv) begin
         state_next   = CONV;
         busy_next    = 1'b1;
         cnt_next     = CNT_W'(T_CONV - 1);
         conv_ch_next = pend_ch;
         conv_ok_next = pend_ok;
         sdo_next     = 1'b0;
         if (!pend_ok) begin
            cfg_err_next = 1'b1;
         end
      end
   end

   // State and datapath registers
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state_reg       <= IDLE;
         cnt_reg         <= '0;
         busy_reg        <= 1'b0;
         conv_ch_reg     <= 3'd0;
         conv_ok_reg     <= 1'b1;
         result_reg      <= 12'h000;
         sdo_shift_reg   <= 12'h000;
         sdo_reg         <= 1'b0;
         cfg_shift_reg   <= 6'b000000;
         rise_cnt_reg    <= 3'd0;
         fall_cnt_reg    <= 4'd0;
         pending_cfg_reg <= CFG_RESET;
         last_cfg_reg    <= 6'b000000;
         cfg_err_reg     <= 1'b0;
         frame_done_reg  <= 1'b0;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         busy_reg        <= busy_next;
         conv_ch_reg     <= conv_ch_next;
         conv_ok_reg     <= conv_ok_next;
         result_reg      <= result_next;
         sdo_shift_reg   <= sdo_shift_next;
         sdo_reg         <= sdo_next;
         cfg_shift_reg   <= cfg_shift_next;
         rise_cnt_reg    <= rise_cnt_next;
         fall_cnt_reg    <= fall_cnt_next;
         pending_cfg_reg <= pending_cfg_next;
         last_cfg_reg    <= last_cfg_next;
         cfg_err_reg     <= cfg_err_next;
         frame_done_reg  <= frame_done_next;
      end
   end

   assign ADC_SDO    = sdo_reg;
   assign busy       = busy_reg;
   assign frame_done = frame_done_reg;
   assign last_cfg   = last_cfg_reg;
   assign cfg_err    = cfg_err_reg;

endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder: scoreboard bench for adc_spi_responder.
// Every conversion pushes its expected 12-bit word.
// Every frame pops one expected word and compares it with the bits read back from SDO.
module tb_adc_spi_responder;

   localparam int NUM_CH = 8;
   localparam int T_CONV = 80;
   localparam int HALF   = 5;    // SCLK half-period in CLOCK cycles (CLOCK/10)

   localparam int MODE_FULL  = 0;
   localparam int MODE_ABORT = 1;
   localparam int MODE_RESET = 2;

   logic                 CLOCK      = 1'b0;
   logic                 RESET      = 1'b1;
   logic                 ADC_SCLK   = 1'b0;
   logic                 ADC_CONVST = 1'b0;
   logic                 ADC_SDI    = 1'b0;
   logic                 ADC_SDO;
   logic [NUM_CH*12-1:0] CH_DATA    = '0;
   logic                 busy;
   logic                 frame_done;
   logic [5:0]           last_cfg;
   logic                 cfg_err;

   logic [11:0] ch_val [0:7];
   logic [11:0] exp_q [$];
   logic [5:0]  model_pending  = 6'b100010;
   logic [5:0]  model_last_cfg = 6'b000000;
   logic [11:0] model_result   = 12'h000;

   int errors      = 0;
   int checks      = 0;
   int fd_count    = 0;
   int busy_cycles = 0;

   adc_spi_responder #(
      .NUM_CH        (NUM_CH),
      .T_CONV        (T_CONV),
      .SCLK_MIN_HALF (4)
   ) dut (
      .CLOCK      (CLOCK),
      .RESET      (RESET),
      .ADC_SCLK   (ADC_SCLK),
      .ADC_CONVST (ADC_CONVST),
      .ADC_SDI    (ADC_SDI),
      .ADC_SDO    (ADC_SDO),
      .CH_DATA    (CH_DATA),
      .busy       (busy),
      .frame_done (frame_done),
      .last_cfg   (last_cfg),
      .cfg_err    (cfg_err)
   );

   always #10 CLOCK = ~CLOCK;

   // Count frame_done pulses and busy-high cycles, sampled away from the active edge
   always @(negedge CLOCK) begin
      if (frame_done) fd_count++;
      if (busy) busy_cycles++;
   end

   // Hard time limit so the run always terminates
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLOCK);
   endtask

   function automatic logic [11:0] model_value(input logic [5:0] cfg);
      logic [2:0] ch;
      ch = {cfg[3], cfg[2], cfg[4]};
      if (!cfg[5] || int'(ch) >= NUM_CH) return 12'h000;
      return ch_val[ch];
   endfunction

   task automatic do_reset();
      RESET = 1'b1;
      tick(3);
      RESET = 1'b0;
      model_pending  = 6'b100010;
      model_last_cfg = 6'b000000;
      model_result   = 12'h000;
      exp_q.delete();
      tick(2);
   endtask

   // Full conversion: CONVST held high past the conversion time
   task automatic conv_full();
      int b0;
      logic [11:0] v;
      b0 = busy_cycles;
      v  = model_value(model_pending);
      model_result = v;
      exp_q.push_back(v);
      ADC_CONVST = 1'b1;
      tick(T_CONV + 4);
      check("busy_len", busy_cycles - b0, T_CONV);
      $display("conv  : cfg=%06b expect=%03h", model_pending, v);
   endtask

   // Early transfer: CONVST falls 20 cycles after its rise, previous result is shifted out
   task automatic conv_early();
      exp_q.push_back(model_result);
      $display("conv  : early, cfg=%06b expect previous=%03h", model_pending, model_result);
      model_result = model_value(model_pending);
      ADC_CONVST = 1'b1;
      tick(20);
   endtask

   // One SPI frame; mode selects normal completion, abort after cut falls, or reset after cut falls
   task automatic run_frame(input logic [5:0] cfg, input int mode, input int cut);
      logic [11:0] word;
      logic [11:0] exp;
      logic [5:0]  sdi_sh;
      int          fd0;
      int          nbits;
      logic [11:0] v;
      word   = 12'h000;
      sdi_sh = cfg;
      fd0    = fd_count;
      nbits  = 12;
      check("sb_has_entry", exp_q.size() > 0, 1);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 12'h000;
      ADC_CONVST = 1'b0;
      tick(4);
      for (int i = 0; i < 12; i++) begin
         ADC_SDI = sdi_sh[5];
         sdi_sh  = {sdi_sh[4:0], 1'b0};
         tick(HALF);
         ADC_SCLK = 1'b1;
         tick(HALF);
         word[11-i] = ADC_SDO;
         ADC_SCLK = 1'b0;
         if (mode != MODE_FULL && i + 1 == cut) begin
            nbits = i + 1;
            break;
         end
      end
      ADC_SDI = 1'b0;
      if (mode == MODE_FULL) begin
         tick(6);
         model_pending  = cfg;
         model_last_cfg = cfg;
         check("frame_word", word, exp);
         check("frame_done_pulses", fd_count - fd0, 1);
         check("last_cfg", last_cfg, model_last_cfg);
         check("sdo_idle", ADC_SDO, 0);
         $display("frame : sent=%06b got=%03h expect=%03h last_cfg=%06b cfg_err=%0b",
                  cfg, word, exp, last_cfg, cfg_err);
      end else begin
         tick(4);
         check("partial_word", word >> (12 - nbits), exp >> (12 - nbits));
         check("sdo_mid", ADC_SDO, exp[11-nbits]);
         if (mode == MODE_ABORT) begin
            v = model_value(model_pending);
            model_result = v;
            exp_q.push_back(v);
            ADC_CONVST = 1'b1;
            tick(4);
            check("abort_sdo", ADC_SDO, 0);
            check("abort_busy", busy, 1);
            check("abort_no_done", fd_count - fd0, 0);
            check("abort_last_cfg", last_cfg, model_last_cfg);
            $display("frame : aborted after %0d falls, sdo=%0b busy=%0b", nbits, ADC_SDO, busy);
            tick(T_CONV + 4);
         end else begin
            RESET = 1'b1;
            #1;
            check("rst_sdo", ADC_SDO, 0);
            check("rst_busy", busy, 0);
            check("rst_frame_done", frame_done, 0);
            check("rst_last_cfg", last_cfg, 6'b000000);
            check("rst_cfg_err", cfg_err, 0);
            $display("frame : reset after %0d falls, sdo=%0b last_cfg=%06b cfg_err=%0b",
                     nbits, ADC_SDO, last_cfg, cfg_err);
            tick(1);
            RESET = 1'b0;
            model_pending  = 6'b100010;
            model_last_cfg = 6'b000000;
            model_result   = 12'h000;
            exp_q.delete();
            tick(2);
         end
      end
   endtask

   logic [5:0] pipe_cfg [0:3];

   initial begin
      ch_val[0] = 12'hA5C;
      ch_val[1] = 12'h3F0;
      ch_val[2] = 12'h123;
      ch_val[3] = 12'h456;
      ch_val[4] = 12'h789;
      ch_val[5] = 12'hABC;
      ch_val[6] = 12'hFFF;
      ch_val[7] = 12'h001;
      for (int i = 0; i < NUM_CH; i++) CH_DATA[12*i +: 12] = ch_val[i];

      pipe_cfg[0] = 6'b110010;   // CH1
      pipe_cfg[1] = 6'b111011;   // CH5, SLP set
      pipe_cfg[2] = 6'b101110;   // CH6, UNI set
      pipe_cfg[3] = 6'b100010;   // CH0

      // Reset state
      tick(3);
      check("reset_sdo", ADC_SDO, 0);
      check("reset_busy", busy, 0);
      check("reset_frame_done", frame_done, 0);
      check("reset_last_cfg", last_cfg, 6'b000000);
      check("reset_cfg_err", cfg_err, 0);
      $display("reset : sdo=%0b busy=%0b last_cfg=%06b cfg_err=%0b", ADC_SDO, busy, last_cfg, cfg_err);
      RESET = 1'b0;
      tick(2);

      // First conversion and config pipelining
      for (int k = 0; k < 4; k++) begin
         conv_full();
         run_frame(pipe_cfg[k], MODE_FULL, 0);
      end
      check("pipe_cfg_err", cfg_err, 0);

      // Abort after 5 SCLK falls, then the restarted conversion completes
      conv_full();
      run_frame(6'b111011, MODE_ABORT, 5);
      run_frame(6'b110010, MODE_FULL, 0);
      check("abort_cfg_err", cfg_err, 0);

      // Early transfer
      do_reset();
      conv_full();
      run_frame(6'b110010, MODE_FULL, 0);
      begin
         int b0;
         b0 = busy_cycles;
         conv_early();
         check("early_busy", busy, 1);
         run_frame(6'b111011, MODE_FULL, 0);
         check("early_busy_len", busy_cycles - b0, T_CONV);
         check("early_cfg_err", cfg_err, 1);
      end
      conv_full();
      run_frame(6'b100010, MODE_FULL, 0);

      // Bad (differential) config
      do_reset();
      conv_full();
      run_frame(6'b000010, MODE_FULL, 0);
      check("bad_cfg_err_before", cfg_err, 0);
      conv_full();
      run_frame(6'b100010, MODE_FULL, 0);
      check("bad_cfg_err_set", cfg_err, 1);
      conv_full();
      run_frame(6'b110010, MODE_FULL, 0);
      check("bad_cfg_err_sticky", cfg_err, 1);

      // Asynchronous reset mid-frame, then a clean frame returns CH0
      conv_full();
      run_frame(6'b110010, MODE_RESET, 5);
      conv_full();
      run_frame(6'b100010, MODE_FULL, 0);
      check("post_reset_cfg_err", cfg_err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
